// File: rtl/mux_arb_nto1.sv
// N-to-1 selector with a one-deep registered output stage, valid/ready handshake on
// every channel and on the output, and either fixed-select or round-robin arbitration.

module mux_arb_nto1_chk #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input logic                Clk,
    input logic                Reset_n,
    input logic [CHANNELS-1:0] InReady,
    input logic [WIDTH-1:0]    M,
    input logic                MValid,
    input logic                MReady
);

    // A stalled output word must stay put until the consumer takes it.
    hold_a: assert property (@(posedge Clk) disable iff (!Reset_n)
        (MValid && !MReady) |=> (MValid && $stable(M)));

    onehot_a: assert property (@(posedge Clk) disable iff (!Reset_n)
        $onehot0(InReady));

endmodule

module mux_arb_nto1 #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    input  logic [CHANNELS*WIDTH-1:0] In,
    input  logic [CHANNELS-1:0]       InValid,
    output logic [CHANNELS-1:0]       InReady,
    input  logic                      Mode,
    input  logic [SEL_W-1:0]          Sel,
    output logic [WIDTH-1:0]          M,
    output logic                      MValid,
    input  logic                      MReady,
    output logic [SEL_W-1:0]          MSrc
);

    logic [CHANNELS-1:0] grant_s;
    logic [SEL_W-1:0]    grant_idx_s;
    logic [SEL_W-1:0]    last_r;
    logic [WIDTH-1:0]    data_s;
    logic                load_en_s;
    logic                xfer_s;
    logic                found_s;
    int                  cand_s;

    // Grant selection: fixed index, or first valid channel after the last winner.
    always_comb begin
        grant_s     = '0;
        grant_idx_s = '0;
        found_s     = 1'b0;
        cand_s      = 0;
        if (Mode == 1'b0) begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (int'(Sel) == k) begin
                    grant_s[k]  = 1'b1;
                    grant_idx_s = SEL_W'(k);
                end else begin
                    grant_s[k] = 1'b0;
                end
            end
        end else begin
            for (int i = 1; i <= CHANNELS; i++) begin
                cand_s = int'(last_r) + i;
                if (cand_s >= CHANNELS) begin
                    cand_s = cand_s - CHANNELS;
                end else begin
                    cand_s = cand_s;
                end
                for (int k = 0; k < CHANNELS; k++) begin
                    if (!found_s && (cand_s == k) && InValid[k]) begin
                        grant_s[k]  = 1'b1;
                        grant_idx_s = SEL_W'(k);
                        found_s     = 1'b1;
                    end else begin
                        found_s = found_s;
                    end
                end
            end
        end
    end

    // Handshake and data steering for the granted channel.
    always_comb begin
        load_en_s = ~MValid | MReady;
        InReady   = grant_s & {CHANNELS{load_en_s}};
        xfer_s    = |(InValid & InReady);
        data_s    = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (grant_s[k]) begin
                data_s = In[k*WIDTH +: WIDTH];
            end else begin
                data_s = data_s;
            end
        end
    end

    // Output register and round-robin pointer; Last only moves on round-robin wins.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            M      <= '0;
            MValid <= 1'b0;
            MSrc   <= '0;
            last_r <= SEL_W'(CHANNELS - 1);
        end else if (xfer_s) begin
            M      <= data_s;
            MSrc   <= grant_idx_s;
            MValid <= 1'b1;
            if (Mode) begin
                last_r <= grant_idx_s;
            end else begin
                last_r <= last_r;
            end
        end else if (MReady) begin
            MValid <= 1'b0;
        end else begin
            MValid <= MValid;
        end
    end

    mux_arb_nto1_chk #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) u_chk (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .InReady (InReady),
        .M       (M),
        .MValid  (MValid),
        .MReady  (MReady)
    );

endmodule

// File: tb/tb_mux_arb_nto1.sv
// Directed bench for mux_arb_nto1: scoreboard of expected output words, plus a
// 3-channel instance for the out-of-range select case.

module tb_mux_arb_nto1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_d;
    logic [3:0]  in_valid, in_ready;
    logic        mode;
    logic [1:0]  sel;
    logic [7:0]  m;
    logic        m_valid, m_ready;
    logic [1:0]  m_src;

    logic [23:0] c3_in;
    logic [2:0]  c3_valid, c3_ready;
    logic        c3_mode;
    logic [1:0]  c3_sel;
    logic [7:0]  c3_m;
    logic        c3_mvalid, c3_mready;
    logic [1:0]  c3_msrc;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [9:0]  sb_q[$];

    always #5 clk = ~clk;

    mux_arb_nto1 dut (
        .Clk(clk), .Reset_n(rst_n), .In(in_d), .InValid(in_valid), .InReady(in_ready),
        .Mode(mode), .Sel(sel), .M(m), .MValid(m_valid), .MReady(m_ready), .MSrc(m_src)
    );

    mux_arb_nto1 #(.WIDTH(8), .CHANNELS(3), .SEL_W(2)) dut3 (
        .Clk(clk), .Reset_n(rst_n), .In(c3_in), .InValid(c3_valid), .InReady(c3_ready),
        .Mode(c3_mode), .Sel(c3_sel), .M(c3_m), .MValid(c3_mvalid), .MReady(c3_mready),
        .MSrc(c3_msrc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: retire a consumed word, queue the expected load (ch < 0: none), check output.
    task automatic cycle(input int ch);
        logic [9:0] e;
        if (m_valid && m_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 32'(sb_q.size()), 32'd1);
            end else begin
                e = sb_q.pop_front();
                chk("pop_data", {24'd0, m}, {24'd0, e[9:2]});
                chk("pop_src", {30'd0, m_src}, {30'd0, e[1:0]});
            end
        end
        if (ch >= 0) sb_q.push_back({in_d[ch*8 +: 8], 2'(ch)});
        @(posedge clk);
        #1;
        chk("mvalid", {31'd0, m_valid}, {31'd0, sb_q.size() != 0});
        if (sb_q.size() != 0) begin
            chk("m", {24'd0, m}, {24'd0, sb_q[0][9:2]});
            chk("msrc", {30'd0, m_src}, {30'd0, sb_q[0][1:0]});
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_d      = 32'h4433_2211;
        in_valid  = 4'b0000;
        mode      = 1'b0;
        sel       = 2'd0;
        m_ready   = 1'b1;
        c3_in     = 24'h33_2211;
        c3_valid  = 3'b000;
        c3_mode   = 1'b0;
        c3_sel    = 2'd0;
        c3_mready = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_m", {24'd0, m}, 32'd0);
        chk("rst_mvalid", {31'd0, m_valid}, 32'd0);
        chk("rst_msrc", {30'd0, m_src}, 32'd0);
        chk("rst_c3_mvalid", {31'd0, c3_mvalid}, 32'd0);

        // Load A5 and stall it, then reset asynchronously between edges.
        rst_n     = 1'b1;
        in_d[7:0] = 8'hA5;
        in_valid  = 4'b1111;
        m_ready   = 1'b0;
        cycle(0);
        in_valid = 4'b0000;
        cycle(-1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_m", {24'd0, m}, 32'd0);
        chk("arst_mvalid", {31'd0, m_valid}, 32'd0);
        chk("arst_msrc", {30'd0, m_src}, 32'd0);
        sb_q.delete();

        // Round-robin from reset: channel 0 first, then rotation.
        in_d     = 32'h4433_2211;
        mode     = 1'b1;
        in_valid = 4'b1111;
        m_ready  = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(0); cycle(1); cycle(2); cycle(3); cycle(0); cycle(1);
        in_valid = 4'b0101;
        cycle(2); cycle(0); cycle(2); cycle(0);

        // Idle drains the output; a lone requester on channel 3 then wins.
        in_valid = 4'b0000;
        cycle(-1); cycle(-1);
        in_valid = 4'b1000;
        cycle(3);
        in_valid = 4'b1111;
        cycle(0); cycle(1);

        // Fixed select steps 0..3 back to back; pointer stays at 1 for the RR cycle after.
        mode = 1'b0;
        sel = 2'd0; cycle(0);
        sel = 2'd1; cycle(1);
        sel = 2'd2; cycle(2);
        sel = 2'd3; cycle(3);
        mode = 1'b1;
        cycle(2);

        // Backpressure: 33 must hold while the source changes to 99.
        mode = 1'b0;
        sel  = 2'd2;
        cycle(2);
        m_ready     = 1'b0;
        in_d[23:16] = 8'h99;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_inready", {28'd0, in_ready}, 32'd0);
            cycle(-1);
        end
        m_ready = 1'b1;
        cycle(2);
        in_valid = 4'b0000;
        cycle(-1);
        sel = 2'd1;
        #1;
        chk("fixed_ready_no_valid", {28'd0, in_ready}, 32'h2);

        // Three channels: Sel = 3 grants nothing and the held word drains.
        c3_valid  = 3'b111;
        c3_sel    = 2'd1;
        c3_mready = 1'b0;
        @(posedge clk);
        #1;
        chk("c3_load_valid", {31'd0, c3_mvalid}, 32'd1);
        chk("c3_load_m", {24'd0, c3_m}, 32'h22);
        chk("c3_load_src", {30'd0, c3_msrc}, 32'd1);
        c3_sel = 2'd3;
        #1;
        chk("c3_oor_ready", {29'd0, c3_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("c3_hold_valid", {31'd0, c3_mvalid}, 32'd1);
        chk("c3_hold_m", {24'd0, c3_m}, 32'h22);
        c3_mready = 1'b1;
        #1;
        chk("c3_oor_ready2", {29'd0, c3_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("c3_drain_valid", {31'd0, c3_mvalid}, 32'd0);
        @(posedge clk);
        #1;
        chk("c3_noload_valid", {31'd0, c3_mvalid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
